pl_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor of the fixed per-stage registers between fetch/decode/execute/memory/writeback.
- Carries an opaque DATA_W payload and a CTRL_W control bundle (regwrite, MemWrite, branch, jump, Result_src, Alu_control, ...) across one stage boundary.
- Adds a valid/ready handshake with a 2-entry skid buffer, so ready is registered and throughput is 1 transfer/cycle.
- Keeps hazard-unit stall and flush semantics; a flush forces control to zero, producing a bubble.

---
 rtl/pl_stage_reg_if.sv | 15 +
 rtl/pl_stage_reg.sv | 105 ++++++++++
 tb/tb_pl_stage_reg.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pl_stage_reg_if.sv
// One side of a pipeline stage boundary: payload, control bundle and handshake.
// A beat moves on a rising edge when valid and ready are both 1. The master
// holds valid, data and ctrl stable until then, and valid never waits on ready.
interface pl_stage_reg_if #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 12
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pl_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer, hazard stall/flush and
// an optional stall-cycle counter (enabled by PL_STAGE_PERF_EN).
module pl_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  pl_stage_reg_if.slave  up,
  pl_stage_reg_if.master dn,
  input  logic           stall,
  input  logic           flush,
  output logic [31:0]    stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } occ_t;

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [CTRL_W-1:0] main_c, skid_c;
  logic              acc, xfer;
  occ_t              occ;

  // Occupancy comes straight from the valid bits; skid is only used behind main.
  assign occ      = occ_t'({skid_v, main_v});
  assign up.ready = rst_n & ~stall & ~skid_v;
  assign acc      = up.valid & up.ready;
  assign xfer     = main_v & dn.ready & ~stall;

  assign dn.valid = main_v;
  assign dn.data  = main_d;
  assign dn.ctrl  = main_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
      main_c <= '0;
      skid_c <= '0;
    end else if (flush) begin
      // Kill both entries as bubbles; payload is left as don't-care.
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_c <= '0;
      skid_c <= '0;
    end else if (!stall) begin
      case (occ)
        EMPTY: begin
          if (acc) begin
            main_v <= 1'b1;
            main_d <= up.data;
            main_c <= up.ctrl;
          end
        end
        ONE: begin
          if (acc && xfer) begin
            main_d <= up.data;
            main_c <= up.ctrl;
          end else if (acc) begin
            skid_v <= 1'b1;
            skid_d <= up.data;
            skid_c <= up.ctrl;
          end else if (xfer) begin
            main_v <= 1'b0;
            main_c <= '0;
          end
        end
        TWO: begin
          if (xfer) begin
            main_d <= skid_d;
            main_c <= skid_c;
            skid_v <= 1'b0;
            skid_c <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PL_STAGE_PERF_EN
  logic [31:0] stall_cnt;

  // Saturating count of edges lost to backpressure or hazard freeze.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (((main_v & ~dn.ready) | stall) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pl_stage_reg.sv
// Bench for pl_stage_reg: queue-based stage model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pl_stage_reg;
  localparam int DW = 160;
  localparam int CW = 12;
  localparam int EW = DW + CW;

  // Clock/reset block
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pl_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pl_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pl_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up           (up_if),
    .dn           (dn_if),
    .stall        (stall),
    .flush        (flush),
    .stall_cycles (stall_cycles)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: entries held by the stage as {ctrl, data}, oldest first.
  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp_cnt = '0;
  logic [DW-1:0] got_q[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update from the stage rules: occupancy limit 2, FIFO, flush kills all.
  always @(posedge clk) begin
    bit rdy;
    rdy = rst_n && !stall && (exp_q.size() < 2);
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      if (((exp_q.size() > 0) && !dn_if.ready) || stall)
        if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      if (flush) begin
        exp_q.delete();
      end else if (!stall) begin
        if ((exp_q.size() > 0) && dn_if.ready) void'(exp_q.pop_front());
        if (up_if.valid && rdy) exp_q.push_back({up_if.ctrl, up_if.data});
      end
    end
    chk_en = 1'b1;
  end

  // Record what the DUT actually hands downstream.
  always @(posedge clk) begin
    if (rst_n && !flush && !stall && dn_if.valid && dn_if.ready)
      got_q.push_back(dn_if.data);
  end

  // Scoreboard compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [EW-1:0] h;
    logic [31:0]   ecnt;
    if (chk_en) begin
      h = (exp_q.size() > 0) ? exp_q[0] : '0;
`ifdef PL_STAGE_PERF_EN
      ecnt = exp_cnt;
`else
      ecnt = 32'h0;
`endif
      chk("in_ready", DW'(up_if.ready), DW'(rst_n && !stall && (exp_q.size() < 2)));
      chk("out_valid", DW'(dn_if.valid), DW'(exp_q.size() > 0));
      chk("out_ctrl", DW'(dn_if.ctrl), DW'(h[EW-1:DW]));
      if (exp_q.size() > 0) chk("out_data", dn_if.data, h[DW-1:0]);
      chk("stall_cycles", DW'(stall_cycles), DW'(ecnt));
    end
  end

  // Driver tasks
  task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input bit ordy, input bit st, input bit fl);
    rst_n       = r;
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = c;
    dn_if.ready = ordy;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic pause();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] perf_exp;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    up_if.ctrl  = '0;
    dn_if.ready = 1'b0;

    // Reset with an offer pending
    repeat (3) step(0, 1, DW'('hDEAD), 12'hFFF, 0, 0, 0);
    pause();
    chk("rst_out_valid", DW'(dn_if.valid), DW'(0));
    chk("rst_out_ctrl", DW'(dn_if.ctrl), DW'(0));
    chk("rst_out_data", dn_if.data, DW'(0));
    chk("rst_in_ready", DW'(up_if.ready), DW'(0));
    chk("rst_stall_cycles", DW'(stall_cycles), DW'(0));
    step(1, 0, '0, '0, 1, 0, 0);
    pause();
    chk("rel_in_ready", DW'(up_if.ready), DW'(1));

    // Streaming 1..8
    got_q.delete();
    for (int i = 1; i <= 8; i++) step(1, 1, DW'(i), CW'(i), 1, 0, 0);
    repeat (2) step(1, 0, '0, '0, 1, 0, 0);
    chk("stream_count", DW'(got_q.size()), DW'(8));
    for (int i = 0; i < got_q.size(); i++) chk("stream_order", got_q[i], DW'(i + 1));

    // Backpressure: A, B fill the stage, C is held off
    got_q.delete();
    step(1, 1, DW'('hA), 12'h001, 0, 0, 0);
    step(1, 1, DW'('hB), 12'h002, 0, 0, 0);
    step(1, 1, DW'('hC), 12'h003, 0, 0, 0);
    pause();
    chk("bp_in_ready", DW'(up_if.ready), DW'(0));
    chk("bp_head", dn_if.data, DW'('hA));
    step(1, 1, DW'('hC), 12'h003, 1, 0, 0);
    step(1, 1, DW'('hC), 12'h003, 1, 0, 0);
    repeat (2) step(1, 0, '0, '0, 1, 0, 0);
    chk("bp_count", DW'(got_q.size()), DW'(3));
    if (got_q.size() == 3) begin
      chk("bp_first", got_q[0], DW'('hA));
      chk("bp_second", got_q[1], DW'('hB));
      chk("bp_third", got_q[2], DW'('hC));
    end

    // Stall with main=A1 and skid=B1
    got_q.delete();
    step(1, 1, DW'('hA1), 12'h0A5, 0, 0, 0);
    step(1, 1, DW'('hB1), 12'h05A, 0, 0, 0);
    repeat (3) step(1, 1, DW'('hC1), 12'h111, 1, 1, 0);
    pause();
    chk("stall_out_data", dn_if.data, DW'('hA1));
    chk("stall_out_ctrl", DW'(dn_if.ctrl), DW'(12'h0A5));
    chk("stall_out_valid", DW'(dn_if.valid), DW'(1));
    chk("stall_in_ready", DW'(up_if.ready), DW'(0));
    chk("stall_no_xfer", DW'(got_q.size()), DW'(0));
    step(1, 0, '0, '0, 1, 0, 0);
    chk("unstall_xfer_count", DW'(got_q.size()), DW'(1));
    if (got_q.size() > 0) chk("unstall_xfer_data", got_q[0], DW'('hA1));
    step(1, 0, '0, '0, 1, 0, 0);
    chk("unstall_drain", DW'(got_q.size()), DW'(2));

    // Flush while full with an offer present
    got_q.delete();
    step(1, 1, DW'('hD), 12'h004, 0, 0, 0);
    step(1, 1, DW'('hE), 12'h005, 0, 0, 0);
    step(1, 1, DW'('hF), 12'h006, 1, 0, 1);
    pause();
    chk("flush_out_valid", DW'(dn_if.valid), DW'(0));
    chk("flush_out_ctrl", DW'(dn_if.ctrl), DW'(0));
    chk("flush_in_ready", DW'(up_if.ready), DW'(1));
    repeat (3) step(1, 0, '0, '0, 1, 0, 0);
    chk("flush_nothing_out", DW'(got_q.size()), DW'(0));

    // Flush beats stall
    step(1, 1, DW'('h9), 12'h007, 0, 0, 0);
    step(1, 0, '0, '0, 0, 1, 1);
    pause();
    chk("flush_stall_valid", DW'(dn_if.valid), DW'(0));
    chk("flush_stall_ctrl", DW'(dn_if.ctrl), DW'(0));
    step(1, 0, '0, '0, 1, 0, 0);
    chk("flush_stall_nothing_out", DW'(got_q.size()), DW'(0));

    // Stall-cycle counter: 5 backpressure + 2 stall edges
`ifdef PL_STAGE_PERF_EN
    perf_exp = 32'd7;
`else
    perf_exp = 32'd0;
`endif
    step(0, 0, '0, '0, 1, 0, 0);
    step(1, 1, DW'('h77), 12'h008, 0, 0, 0);
    repeat (5) step(1, 0, '0, '0, 0, 0, 0);
    repeat (2) step(1, 0, '0, '0, 1, 1, 0);
    pause();
    chk("perf_count", DW'(stall_cycles), DW'(perf_exp));
    step(1, 0, '0, '0, 1, 0, 1);
    pause();
    chk("perf_after_flush", DW'(stall_cycles), DW'(perf_exp));
    step(0, 0, '0, '0, 1, 0, 0);
    pause();
    chk("perf_after_reset", DW'(stall_cycles), DW'(0));
    step(1, 0, '0, '0, 1, 0, 0);
    step(1, 0, '0, '0, 1, 0, 0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
